// File: rtl/multdiv_sequencer_pkg.sv
// Shared constants and state encoding for the multiply/divide sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package multdiv_sequencer_pkg;

    localparam int MULTDIV_ITERS = 16;
    localparam int MULTDIV_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/multdiv_sequencer_if.sv
// Control/status bundle between execute control and the multdiv sequencer.
// Latency: n/a (wires only).
// Backpressure: none; busy tells the pipeline to stall.
interface multdiv_sequencer_if #(
    parameter int CNT_W = 4
);
    logic             ctrl_mult;
    logic             ctrl_div;
    logic             div_zero;
    logic             load_en;
    logic             step_en;
    logic             op_div;
    logic [CNT_W-1:0] iter;
    logic             busy;
    logic             data_ready;
    logic             exception;

    // Execute control side: issues starts, reads status.
    modport master (
        output ctrl_mult, ctrl_div, div_zero,
        input  load_en, step_en, op_div, iter, busy, data_ready, exception
    );

    // Sequencer side.
    modport slave (
        input  ctrl_mult, ctrl_div, div_zero,
        output load_en, step_en, op_div, iter, busy, data_ready, exception
    );
endinterface

// File: rtl/multdiv_sequencer_iter_counter.sv
// Iteration counter: CNT_W-bit synchronous up-counter built from T flip-flops.
// Latency: q advances one edge after en is sampled high; wraps naturally.
// Backpressure: none; en alone gates counting.
module multdiv_sequencer_iter_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] t;

    // Bit i toggles when enabled and every lower bit is 1.
    assign t[0] = en;
    for (genvar i = 1; i < CNT_W; i++) begin : g_toggle
        assign t[i] = en & (&q[i-1:0]);
    end

    // T flip-flop bank.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q <= '0;
        end else begin
            q <= q ^ t;
        end
    end

endmodule

// File: rtl/multdiv_sequencer.sv
// Control FSM for the iterative multiply/divide datapath: load, ITERS steps, done pulse.
// Latency: result strobe 18 cycles after the start edge (2 on divide-by-zero).
// Backpressure: starts are dropped unless IDLE; busy stalls the pipeline while in flight.
module multdiv_sequencer
    import multdiv_sequencer_pkg::*;
#(
    parameter int ITERS = MULTDIV_ITERS,
    parameter int CNT_W = MULTDIV_CNT_W
) (
    input  logic                clk,
    input  logic                clr,
    multdiv_sequencer_if.slave  bus
);

    // The terminal count is decoded as all-ones, so the iteration count
    // must be an exact power of two of the counter width.
    if (ITERS != (1 << CNT_W)) begin : g_bad_iters
        $error("multdiv_sequencer: ITERS must equal 2**CNT_W");
    end

    state_t           state;
    logic             load_q;
    logic             step_q;
    logic             busy_q;
    logic             rdy_q;
    logic             exc_q;
    logic             exc_latch;
    logic             op_q;
    logic [CNT_W-1:0] iter_q;
    logic             cnt_en;
    logic             term_cnt;

    assign cnt_en   = (state == ST_RUN);
    assign term_cnt = &iter_q;

    // Counter only runs in RUN; it wraps to 0 on the last RUN edge, so it
    // always reads 0 in IDLE/INIT/DONE without needing a separate clear.
    multdiv_sequencer_iter_counter #(
        .CNT_W (CNT_W)
    ) u_iter_counter (
        .clk (clk),
        .clr (clr),
        .en  (cnt_en),
        .q   (iter_q)
    );

    // State machine; outputs are registered alongside the state so they are
    // pure functions of the current state with no input-to-output paths.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= ST_IDLE;
            load_q    <= 1'b0;
            step_q    <= 1'b0;
            busy_q    <= 1'b0;
            rdy_q     <= 1'b0;
            exc_q     <= 1'b0;
            exc_latch <= 1'b0;
            op_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.ctrl_mult || bus.ctrl_div) begin
                        state  <= ST_INIT;
                        // Multiply wins a simultaneous request.
                        op_q   <= bus.ctrl_div & ~bus.ctrl_mult;
                        load_q <= 1'b1;
                        busy_q <= 1'b1;
                    end
                end
                ST_INIT: begin
                    load_q <= 1'b0;
                    if (op_q && bus.div_zero) begin
                        // Skip iterations; report the exception immediately.
                        state     <= ST_DONE;
                        exc_latch <= 1'b1;
                        rdy_q     <= 1'b1;
                        exc_q     <= 1'b1;
                    end else begin
                        state     <= ST_RUN;
                        exc_latch <= 1'b0;
                        step_q    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (term_cnt) begin
                        state  <= ST_DONE;
                        step_q <= 1'b0;
                        rdy_q  <= 1'b1;
                        exc_q  <= exc_latch;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                    rdy_q  <= 1'b0;
                    exc_q  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.load_en    = load_q;
    assign bus.step_en    = step_q;
    assign bus.busy       = busy_q;
    assign bus.data_ready = rdy_q;
    assign bus.exception  = exc_q;
    assign bus.op_div     = op_q;
    assign bus.iter       = iter_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer: vector table plus corner-case sequences.
// Results are checked by a scoreboard popped on every data_ready.
// All driving and sampling happens on the falling clock edge.
module tb_multdiv_sequencer;
    import multdiv_sequencer_pkg::*;

    logic clk = 1'b0;
    logic clr;

    always #5 clk = ~clk;

    multdiv_sequencer_if #(.CNT_W(4)) bus ();

    multdiv_sequencer #(
        .ITERS (16),
        .CNT_W (4)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    int         checks   = 0;
    int         errors   = 0;
    int         dr_count = 0;
    logic [1:0] sb[$];
    logic [1:0] sb_e;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every result strobe must match the oldest expected result;
    // exception must never appear without data_ready.
    always @(negedge clk) begin
        if (bus.data_ready) begin
            dr_count++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_data_ready: got 1, expected 0 (t=%0t)", $time);
            end else begin
                sb_e = sb.pop_front();
                chk("sb_op_div", int'(bus.op_div), int'(sb_e[1]));
                chk("sb_exception", int'(bus.exception), int'(sb_e[0]));
            end
        end else begin
            chk("exc_unqualified", int'(bus.exception), 0);
        end
    end

    // Issue one operation from a falling edge and observe it until idle.
    // inj in 0..15: pulse ctrl_div during RUN at that iter; inj == 16: pulse
    // ctrl_mult during the DONE cycle. Returns at the falling edge where busy
    // is first seen low, so a following call starts back-to-back.
    task automatic run_op(input logic m, input logic d, input logic dz, input int inj,
                          output int lat, output int steps, output int loads,
                          output int busy_n, output int iter_err, output int op_err,
                          output int exc_seen);
        logic exp_op;
        bit   done;
        exp_op   = d & ~m;
        lat      = 0;
        steps    = 0;
        loads    = 0;
        busy_n   = 0;
        iter_err = 0;
        op_err   = 0;
        exc_seen = -1;
        done     = 0;
        sb.push_back({exp_op, exp_op & dz});
        bus.ctrl_mult = m;
        bus.ctrl_div  = d;
        bus.div_zero  = dz;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            bus.ctrl_mult = 1'b0;
            bus.ctrl_div  = 1'b0;
            if (bus.load_en) loads++;
            if (bus.busy) begin
                busy_n++;
                if (bus.op_div !== exp_op) op_err++;
            end
            if (bus.step_en) begin
                if (bus.iter !== 4'(steps)) iter_err++;
                if (steps == inj) bus.ctrl_div = 1'b1;
                steps++;
            end
            if (bus.data_ready && lat == 0) begin
                lat      = cyc;
                exc_seen = int'(bus.exception);
                if (inj == 16) bus.ctrl_mult = 1'b1;
            end
            if (!bus.busy) begin
                done = 1;
                break;
            end
        end
        if (!done) chk("op_timeout", 1, 0);
    endtask

    typedef struct {
        string name;
        logic  m;
        logic  d;
        logic  dz;
        int    inj;
        int    exp_op;
        int    exp_exc;
        int    exp_lat;
        int    exp_steps;
        int    exp_busy;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int lat, steps, loads, busy_n, iter_err, op_err, exc_seen, dr_before;
        bit hit;

        vecs[0] = '{"mult",         1'b1, 1'b0, 1'b0, -1, 0, 0, 18, 16, 18};
        vecs[1] = '{"div",          1'b0, 1'b1, 1'b0, -1, 1, 0, 18, 16, 18};
        vecs[2] = '{"div_zero",     1'b0, 1'b1, 1'b1, -1, 1, 1,  2,  0,  2};
        vecs[3] = '{"both",         1'b1, 1'b1, 1'b0, -1, 0, 0, 18, 16, 18};
        vecs[4] = '{"both_dz",      1'b1, 1'b1, 1'b1, -1, 0, 0, 18, 16, 18};
        vecs[5] = '{"mult_dz",      1'b1, 1'b0, 1'b1, -1, 0, 0, 18, 16, 18};
        vecs[6] = '{"div_inj_run",  1'b0, 1'b1, 1'b0,  7, 1, 0, 18, 16, 18};
        vecs[7] = '{"mult_inj_done",1'b1, 1'b0, 1'b0, 16, 0, 0, 18, 16, 18};

        bus.ctrl_mult = 1'b0;
        bus.ctrl_div  = 1'b0;
        bus.div_zero  = 1'b0;
        clr           = 1'b1;

        // Reset held with start pulses toggling: everything stays quiet.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_outputs", int'({bus.load_en, bus.step_en, bus.busy,
                                     bus.data_ready, bus.exception, bus.op_div}), 0);
            chk("rst_iter", int'(bus.iter), 0);
            bus.ctrl_mult = ~bus.ctrl_mult;
        end
        @(negedge clk);
        bus.ctrl_mult = 1'b0;
        clr           = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_busy", int'(bus.busy), 0);
            chk("post_rst_load", int'(bus.load_en), 0);
        end

        // Vector table.
        foreach (vecs[i]) begin
            dr_before = dr_count;
            run_op(vecs[i].m, vecs[i].d, vecs[i].dz, vecs[i].inj,
                   lat, steps, loads, busy_n, iter_err, op_err, exc_seen);
            chk({vecs[i].name, "_latency"}, lat, vecs[i].exp_lat);
            chk({vecs[i].name, "_steps"}, steps, vecs[i].exp_steps);
            chk({vecs[i].name, "_loads"}, loads, 1);
            chk({vecs[i].name, "_busy_cycles"}, busy_n, vecs[i].exp_busy);
            chk({vecs[i].name, "_iter_seq_err"}, iter_err, 0);
            chk({vecs[i].name, "_op_div_err"}, op_err, 0);
            chk({vecs[i].name, "_exception"}, exc_seen, vecs[i].exp_exc);
            repeat (2) begin
                @(negedge clk);
                chk({vecs[i].name, "_idle_busy"}, int'(bus.busy), 0);
                chk({vecs[i].name, "_idle_load"}, int'(bus.load_en), 0);
                chk({vecs[i].name, "_op_div_held"}, int'(bus.op_div), vecs[i].exp_op);
            end
            chk({vecs[i].name, "_ready_count"}, dr_count - dr_before, 1);
            bus.div_zero = 1'b0;
        end

        // Back-to-back: second start in the cycle right after data_ready.
        dr_before = dr_count;
        run_op(1'b1, 1'b0, 1'b0, -1, lat, steps, loads, busy_n, iter_err, op_err, exc_seen);
        chk("b2b_first_latency", lat, 18);
        run_op(1'b1, 1'b0, 1'b0, -1, lat, steps, loads, busy_n, iter_err, op_err, exc_seen);
        chk("b2b_second_latency", lat, 18);
        chk("b2b_second_busy", busy_n, 18);
        chk("b2b_second_steps", steps, 16);
        chk("b2b_ready_count", dr_count - dr_before, 2);

        // Mid-operation reset at iter 9 of a divide: aborted, never reports.
        dr_before     = dr_count;
        hit           = 0;
        bus.ctrl_div  = 1'b1;
        bus.div_zero  = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            bus.ctrl_div = 1'b0;
            if (bus.step_en && bus.iter == 4'd9) begin
                clr = 1'b1;
                #1;
                chk("abort_iter", int'(bus.iter), 0);
                chk("abort_busy", int'(bus.busy), 0);
                chk("abort_step", int'(bus.step_en), 0);
                chk("abort_op_div", int'(bus.op_div), 0);
                hit = 1;
                break;
            end
        end
        chk("abort_reached_iter9", int'(hit), 1);
        @(negedge clk);
        clr = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_no_ready", dr_count - dr_before, 0);
        chk("abort_idle_busy", int'(bus.busy), 0);
        run_op(1'b1, 1'b0, 1'b0, -1, lat, steps, loads, busy_n, iter_err, op_err, exc_seen);
        chk("after_abort_latency", lat, 18);
        chk("after_abort_iter_err", iter_err, 0);
        @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
- Control FSM for the processor's iterative multiply/divide unit (radix-4 Booth multiply, restoring divide; 16 iterations each).
- Latches the requested operation, emits operand-load and per-iteration step strobes, counts iterations with a 4-bit cycle counter, and reports completion and exceptions.
- Drives the pipeline stall while an operation is in flight.
- Sits between the decode/execute control and the multdiv datapath.

Parameters:
- ITERS, 16, number of datapath iterations per operation (must equal 2^CNT_W).
- CNT_W, 4, iteration counter width.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous, active-high reset.
- ctrl_mult  in  1  one-cycle start pulse for multiply.
- ctrl_div  in  1  one-cycle start pulse for divide.
- div_zero  in  1  divisor-is-zero flag from the datapath, valid in INIT.
- load_en  out  1  load operands into the datapath registers.
- step_en  out  1  advance the datapath by one iteration.
- op_div  out  1  latched operation: 0 = mult, 1 = div.
- iter  out  CNT_W  current iteration index.
- busy  out  1  operation in flight; the pipeline stalls on this.
- data_ready  out  1  one-cycle pulse: result valid.
- exception  out  1  qualified with data_ready: divide by zero.

Behaviour:
- States: IDLE, INIT, RUN, DONE. Encoding is free; the reset state is IDLE.
- Reset (clr=1, asynchronous) forces:
  - state = IDLE, iter = 0, op_div = 0;
  - load_en = step_en = busy = data_ready = exception = 0.
- Reset asserted mid-operation aborts the operation. No data_ready is ever produced for that operation.
- IDLE:
  - If ctrl_mult or ctrl_div is high at an edge, go to INIT. op_div <= ctrl_div & ~ctrl_mult, so mult wins if both are high. Clear iter.
  - Otherwise stay in IDLE.
- INIT (exactly 1 cycle):
  - load_en = 1, busy = 1.
  - If op_div and div_zero: go to DONE with the exception latch set.
  - Otherwise go to RUN, with the exception latch cleared.
- RUN (exactly ITERS cycles):
  - step_en = 1, busy = 1.
  - iter increments at each edge. It shows 0 in the first RUN cycle and ITERS-1 in the last.
  - When iter == ITERS-1, go to DONE. iter wraps to 0 on that edge.
- DONE (exactly 1 cycle):
  - data_ready = 1, busy = 1; exception = latch value.
  - Go to IDLE next cycle.
- All outputs are Moore (decoded from registered state), with no combinational input-to-output paths.
- Latency:
  - Start pulse sampled at edge E0; load_en high in cycle E0..E1.
  - step_en high for 16 cycles, E1..E17.
  - data_ready high in cycle E17..E18, i.e. 18 cycles after the start edge.
  - Div-by-zero: data_ready in cycle E1..E2, 2 cycles after the start edge.
- busy is high in every non-IDLE state.
- Start pulses arriving while not in IDLE are ignored; no queuing. A start in the DONE cycle is also ignored. The next accepted start is the one sampled in IDLE.
- op_div is held stable from INIT through DONE and retains its value in IDLE.
- exception is 0 whenever data_ready is 0.
- The iter counter:
  - is enabled only in RUN;
  - holds its value in INIT and DONE;
  - cannot overflow past ITERS-1 because the FSM exits RUN on the terminal count.

Decomposition:
- Shared package/header constants:
  - state encodings ST_IDLE, ST_INIT, ST_RUN, ST_DONE;
  - MULTDIV_ITERS = 16;
  - MULTDIV_CNT_W = 4.
- One natural sub-module, iter_counter:
  - CNT_W-bit synchronous up-counter built from T flip-flops;
  - ports: clk, clr (async), en, q;
  - terminal count = &q decoded in the parent.
- The FSM next-state and output decode stay in multdiv_sequencer.

Test Plan:
- Reset: hold clr=1 for 3 cycles with ctrl_mult pulsing -> all outputs 0, state IDLE. Release clr -> still idle, no busy.
- Multiply: pulse ctrl_mult at edge 0 -> load_en in cycle 0–1; step_en for exactly 16 cycles with iter 0..15; data_ready=1 and exception=0 in cycle 17–18; op_div=0 throughout; busy exactly 18 cycles.
- Divide by zero: pulse ctrl_div with div_zero=1 -> load_en 1 cycle, no step_en, data_ready=1 and exception=1 on the next cycle, op_div=1, busy 2 cycles.
- Collision and ignore:
  - ctrl_mult and ctrl_div together -> op_div=0.
  - Extra ctrl_div at RUN iter=7 -> ignored; iter continues 8..15; a single data_ready.
  - Back-to-back: ctrl_mult in the cycle after data_ready -> new operation accepted, full 18-cycle latency.
- Mid-op reset: pulse ctrl_div (div_zero=0), assert clr at iter=9 -> immediate IDLE, iter=0, no data_ready. A subsequent ctrl_mult completes normally.
